// File: rtl/vchanel_demux.sv
// Virtual-channel ingress distributor: pops an upstream FIFO and pushes each word into vchanel FIFO 0..3.
// Optional stall counter is enabled by defining VCHANEL_DEMUX_STATS_EN.
module vchanel_demux #(
   parameter int unsigned DATA_W     = 4,
   parameter int unsigned SKID_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enb,
   input  logic              in_empty,
   output logic              in_pop,
   input  logic [DATA_W-1:0] in_data,
   input  logic [1:0]        in_dest,
   input  logic              full_vchanel0,
   input  logic              full_vchanel1,
   input  logic              full_vchanel2,
   input  logic              full_vchanel3,
   output logic              push_vchanel0,
   output logic              push_vchanel1,
   output logic              push_vchanel2,
   output logic              push_vchanel3,
   output logic [DATA_W-1:0] data_vchanel0,
   output logic [DATA_W-1:0] data_vchanel1,
   output logic [DATA_W-1:0] data_vchanel2,
   output logic [DATA_W-1:0] data_vchanel3,
   output logic              idle
`ifdef VCHANEL_DEMUX_STATS_EN
   ,
   output logic [7:0]        stall_count
`endif
);

   localparam logic [2:0] LP_SKID = 3'(SKID_DEPTH);

   // Skid buffer: entry 0 is always the head.
   logic [DATA_W-1:0] r_skid_data [0:SKID_DEPTH-1];
   logic [1:0]        r_skid_dest [0:SKID_DEPTH-1];
   logic [1:0]        r_cnt;
   logic              r_pop_d;
   logic [3:0]        r_push;
   logic [DATA_W-1:0] r_data [0:3];
   logic              r_idle;

   logic [3:0]        w_full;
   logic [2:0]        w_occ;
   logic              w_in_pop;
   logic              w_cand_valid;
   logic              w_from_skid;
   logic [1:0]        w_cand_dest;
   logic [DATA_W-1:0] w_cand_data;
   logic              w_dest_full;
   logic              w_dispatch;
   logic              w_head_pop;
   logic              w_append;
   logic [1:0]        w_cnt_next;
   logic [DATA_W-1:0] w_skid_data_next [0:SKID_DEPTH-1];
   logic [1:0]        w_skid_dest_next [0:SKID_DEPTH-1];
   logic [3:0]        w_push_next;
   logic [DATA_W-1:0] w_data_next [0:3];

   assign w_full = {full_vchanel3, full_vchanel2, full_vchanel1, full_vchanel0};

   // Occupancy counts the word already in flight so every popped word has a slot.
   assign w_occ    = {1'b0, r_cnt} + {2'b00, r_pop_d};
   assign w_in_pop = rst & enb & ~in_empty & (w_occ < LP_SKID);
   assign in_pop   = w_in_pop;

   always_comb begin
      w_cand_valid = (r_cnt != 2'd0) || r_pop_d;
      w_from_skid  = (r_cnt != 2'd0);
      w_cand_dest  = in_dest;
      w_cand_data  = in_data;
      if (w_from_skid) begin
         w_cand_dest = r_skid_dest[0];
         w_cand_data = r_skid_data[0];
      end
      w_dest_full = w_full[w_cand_dest];
      w_dispatch  = w_cand_valid && enb && !w_dest_full;
   end

   always_comb begin
      w_push_next = '0;
      w_data_next = r_data;
      if (w_dispatch) begin
         w_push_next[w_cand_dest] = 1'b1;
         w_data_next[w_cand_dest] = w_cand_data;
      end
   end

   // Head removal is applied before the append so an arrival lands behind what remains.
   always_comb begin
      w_skid_data_next = r_skid_data;
      w_skid_dest_next = r_skid_dest;
      w_cnt_next       = r_cnt;
      w_head_pop       = w_dispatch && w_from_skid;
      w_append         = r_pop_d && !(w_dispatch && !w_from_skid);
      if (w_head_pop) begin
         w_skid_data_next[0] = r_skid_data[1];
         w_skid_dest_next[0] = r_skid_dest[1];
         w_cnt_next          = r_cnt - 2'd1;
      end
      if (w_append) begin
         w_skid_data_next[w_cnt_next[0]] = in_data;
         w_skid_dest_next[w_cnt_next[0]] = in_dest;
         w_cnt_next                      = w_cnt_next + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt       <= '0;
         r_pop_d     <= 1'b0;
         r_skid_data <= '{default: '0};
         r_skid_dest <= '{default: '0};
         r_push      <= '0;
         r_data      <= '{default: '0};
         r_idle      <= 1'b1;
      end else begin
         r_cnt       <= w_cnt_next;
         r_pop_d     <= w_in_pop;
         r_skid_data <= w_skid_data_next;
         r_skid_dest <= w_skid_dest_next;
         r_push      <= w_push_next;
         r_data      <= w_data_next;
         r_idle      <= (w_cnt_next == 2'd0) && !w_in_pop;
      end
   end

   assign push_vchanel0 = r_push[0];
   assign push_vchanel1 = r_push[1];
   assign push_vchanel2 = r_push[2];
   assign push_vchanel3 = r_push[3];
   assign data_vchanel0 = r_data[0];
   assign data_vchanel1 = r_data[1];
   assign data_vchanel2 = r_data[2];
   assign data_vchanel3 = r_data[3];
   assign idle          = r_idle;

`ifdef VCHANEL_DEMUX_STATS_EN
   logic [7:0] r_stall;
   logic       w_stall;

   assign w_stall = w_cand_valid && enb && w_dest_full;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_stall <= '0;
      end else if (w_stall && (r_stall != 8'hFF)) begin
         r_stall <= r_stall + 8'd1;
      end
   end

   assign stall_count = r_stall;
`else
   // Stall counter absent in this build.
`endif

endmodule

// File: tb/tb_vchanel_demux.sv
// Self-checking bench for vchanel_demux: cycle table for reset/streaming plus scoreboarded corner sequences.
module tb_vchanel_demux;

   logic       clk = 1'b0;
   logic       rst;
   logic       enb;
   logic       in_empty;
   logic       in_pop;
   logic [3:0] in_data;
   logic [1:0] in_dest;
   logic       full_vchanel0, full_vchanel1, full_vchanel2, full_vchanel3;
   logic       push_vchanel0, push_vchanel1, push_vchanel2, push_vchanel3;
   logic [3:0] data_vchanel0, data_vchanel1, data_vchanel2, data_vchanel3;
   logic       idle;
`ifdef VCHANEL_DEMUX_STATS_EN
   logic [7:0] stall_count;
`endif

   vchanel_demux #(.DATA_W(4), .SKID_DEPTH(2)) dut (
      .clk(clk), .rst(rst), .enb(enb), .in_empty(in_empty), .in_pop(in_pop),
      .in_data(in_data), .in_dest(in_dest),
      .full_vchanel0(full_vchanel0), .full_vchanel1(full_vchanel1),
      .full_vchanel2(full_vchanel2), .full_vchanel3(full_vchanel3),
      .push_vchanel0(push_vchanel0), .push_vchanel1(push_vchanel1),
      .push_vchanel2(push_vchanel2), .push_vchanel3(push_vchanel3),
      .data_vchanel0(data_vchanel0), .data_vchanel1(data_vchanel1),
      .data_vchanel2(data_vchanel2), .data_vchanel3(data_vchanel3),
      .idle(idle)
`ifdef VCHANEL_DEMUX_STATS_EN
      , .stall_count(stall_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] dest;
      logic [3:0] data;
   } word_t;

   typedef struct {
      logic       enb;
      logic [3:0] full;
      logic       exp_pop;
      logic [3:0] exp_push;
      logic       exp_idle;
   } vec_t;

   word_t      upq[$];
   word_t      sbq[$];
   logic [3:0] last_data [4];
   logic [3:0] w_push;
   logic [3:0] w_dv [4];
   int         checks   = 0;
   int         failures = 0;
   int         push_total = 0;

   assign w_push = {push_vchanel3, push_vchanel2, push_vchanel1, push_vchanel0};
   assign w_dv[0] = data_vchanel0;
   assign w_dv[1] = data_vchanel1;
   assign w_dv[2] = data_vchanel2;
   assign w_dv[3] = data_vchanel3;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic set_full(input logic [3:0] f);
      {full_vchanel3, full_vchanel2, full_vchanel1, full_vchanel0} = f;
   endtask

   task automatic preload(input logic [1:0] dest, input logic [3:0] data);
      word_t w;
      w.dest = dest;
      w.data = data;
      upq.push_back(w);
      in_empty = (upq.size() == 0);
   endtask

   // Samples at negedge, scoreboards pushes, then models the upstream FIFO after the edge.
   task automatic tick(output logic o_pop, output logic [3:0] o_push, output logic o_idle);
      word_t w;
      @(negedge clk);
      o_pop  = in_pop;
      o_push = w_push;
      o_idle = idle;
      chk("skid_cnt_max", 32'(dut.r_cnt <= 2'd2), 32'd1);
      chk("push_onehot", 32'($countones(w_push) <= 1), 32'd1);
      for (int ch = 0; ch < 4; ch++) begin
         if (w_push[ch]) begin
            push_total++;
            checks++;
            if (sbq.size() == 0) begin
               failures++;
               $display("FAIL unexpected_push ch=%0d actual=push required=none", ch);
            end else begin
               w = sbq.pop_front();
               chk($sformatf("push_dest_ch%0d", ch), ch, 32'(w.dest));
               last_data[ch] = w.data;
            end
         end
         chk($sformatf("data_ch%0d", ch), 32'(w_dv[ch]), 32'(last_data[ch]));
      end
      @(posedge clk);
      #1;
      if (o_pop) begin
         if (upq.size() > 0) begin
            w = upq.pop_front();
            in_dest = w.dest;
            in_data = w.data;
            sbq.push_back(w);
         end else begin
            chk("pop_while_empty", 32'd1, 32'd0);
         end
      end
      in_empty = (upq.size() == 0);
   endtask

   task automatic clear_model();
      sbq.delete();
      for (int ch = 0; ch < 4; ch++) last_data[ch] = 4'h0;
   endtask

   task automatic drain(input string name, input int max_ticks);
      logic p, id;
      logic [3:0] pu;
      bit done = 0;
      for (int i = 0; i < max_ticks && !done; i++) begin
         tick(p, pu, id);
         if (sbq.size() == 0 && upq.size() == 0 && id) done = 1;
      end
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL %s_drain_timeout actual=pending%0d required=0", name, sbq.size());
      end
   endtask

   initial begin
      vec_t       tbl [7];
      logic       p, id;
      logic [3:0] pu;
      int         base;

      tbl[0] = '{1'b1, 4'h0, 1'b1, 4'b0000, 1'b1};
      tbl[1] = '{1'b1, 4'h0, 1'b1, 4'b0000, 1'b0};
      tbl[2] = '{1'b1, 4'h0, 1'b1, 4'b0001, 1'b0};
      tbl[3] = '{1'b1, 4'h0, 1'b1, 4'b0010, 1'b0};
      tbl[4] = '{1'b1, 4'h0, 1'b0, 4'b0100, 1'b0};
      tbl[5] = '{1'b1, 4'h0, 1'b0, 4'b1000, 1'b1};
      tbl[6] = '{1'b1, 4'h0, 1'b0, 4'b0000, 1'b1};

      rst = 1'b0; enb = 1'b1; in_data = 4'h0; in_dest = 2'd0; in_empty = 1'b1;
      set_full(4'h0);
      clear_model();
      preload(2'd0, 4'hA); preload(2'd1, 4'hB); preload(2'd2, 4'hC); preload(2'd3, 4'hD);

      // Reset held with a non-empty upstream.
      for (int i = 0; i < 3; i++) begin
         tick(p, pu, id);
         chk("rst_in_pop", 32'(p), 32'd0);
         chk("rst_push", 32'(pu), 32'd0);
         chk("rst_idle", 32'(id), 32'd1);
      end
      clear_model();
      rst = 1'b1;

      // Streaming A,B,C,D to channels 0..3.
      for (int i = 0; i < 7; i++) begin
         enb = tbl[i].enb;
         set_full(tbl[i].full);
         tick(p, pu, id);
         chk($sformatf("stream_pop_t%0d", i), 32'(p), 32'(tbl[i].exp_pop));
         chk($sformatf("stream_push_t%0d", i), 32'(pu), 32'(tbl[i].exp_push));
         chk($sformatf("stream_idle_t%0d", i), 32'(id), 32'(tbl[i].exp_idle));
      end
      chk("stream_done", 32'(sbq.size() + upq.size()), 32'd0);

      // Backpressure on channel 2.
      base = push_total;
      set_full(4'b0100);
      for (int i = 1; i <= 6; i++) preload(2'd2, 4'(i));
      for (int i = 0; i < 6; i++) begin
         tick(p, pu, id);
         chk($sformatf("bp_push_t%0d", i), 32'(pu), 32'd0);
         if (i >= 2) chk($sformatf("bp_pop_t%0d", i), 32'(p), 32'd0);
      end
      chk("bp_cnt_sat", 32'(dut.r_cnt), 32'd2);
      set_full(4'h0);
      drain("bp", 40);
      chk("bp_push_count", push_total - base, 6);

      // Head-of-line blocking.
      base = push_total;
      set_full(4'b0100);
      preload(2'd2, 4'h1); preload(2'd0, 4'h2);
      for (int i = 0; i < 6; i++) begin
         tick(p, pu, id);
         chk($sformatf("hol_push_t%0d", i), 32'(pu), 32'd0);
      end
      set_full(4'h0);
      drain("hol", 20);
      chk("hol_push_count", push_total - base, 2);

      // Enable drops while a word is in flight.
      base = push_total;
      preload(2'd1, 4'h7);
      tick(p, pu, id);
      chk("enb_first_pop", 32'(p), 32'd1);
      enb = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick(p, pu, id);
         chk($sformatf("enb_off_push_t%0d", i), 32'(pu), 32'd0);
      end
      chk("enb_off_idle", 32'(id), 32'd0);
      chk("enb_off_cnt", 32'(dut.r_cnt), 32'd1);
      enb = 1'b1;
      drain("enb", 20);
      chk("enb_push_count", push_total - base, 1);

      // Reset with a full skid discards everything.
      base = push_total;
      set_full(4'b1000);
      preload(2'd3, 4'h8); preload(2'd3, 4'h9);
      for (int i = 0; i < 4; i++) tick(p, pu, id);
      chk("rstmid_cnt_before", 32'(dut.r_cnt), 32'd2);
      rst = 1'b0;
      tick(p, pu, id);
      chk("rstmid_pop", 32'(p), 32'd0);
      clear_model();
      rst = 1'b1;
      set_full(4'h0);
      for (int i = 0; i < 5; i++) begin
         tick(p, pu, id);
         chk($sformatf("rstmid_push_t%0d", i), 32'(pu), 32'd0);
      end
      chk("rstmid_idle", 32'(id), 32'd1);
      chk("rstmid_push_count", push_total - base, 0);

`ifdef VCHANEL_DEMUX_STATS_EN
      rst = 1'b0;
      tick(p, pu, id);
      clear_model();
      rst = 1'b1;
      chk("stats_reset", 32'(stall_count), 32'd0);
      set_full(4'b0010);
      preload(2'd1, 4'h5);
      tick(p, pu, id);
      for (int i = 0; i < 10; i++) tick(p, pu, id);
      chk("stats_10", 32'(stall_count), 32'd10);
      for (int i = 0; i < 290; i++) tick(p, pu, id);
      chk("stats_sat", 32'(stall_count), 32'd255);
      set_full(4'h0);
      drain("stats", 20);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/vchanel_demux.md
Name: vchanel_demux

Overview:
- Distributor at the ingress end of the virtual-channel path; it is the write side feeding the four vchanel FIFOs that the weighted round-robin stage later drains.
- Pops words from a single upstream FIFO (pop/empty protocol, read data valid one cycle after pop).
- Each word carries a 2-bit destination field. The block pushes the word into vchanel FIFO 0..3 and honours that FIFO's full flag.
- A 2-entry in-order skid buffer absorbs backpressure, so words already popped are never lost.

Parameters:
DATA_W, 4, payload width of each word and of every data_vchanelN output
SKID_DEPTH, 2, skid buffer entries; fixed at 2 (in_pop throttle below assumes 2)

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  synchronous, active-low reset; sampled on rising edge of clk
enb  input  1  block enable; when low, no new pops and no pushes
in_empty  input  1  upstream FIFO empty flag
in_pop  output  1  pop request to upstream FIFO (combinational)
in_data  input  DATA_W  upstream read data; valid the cycle after in_pop was high
in_dest  input  2  destination channel for in_data; same timing as in_data
full_vchanel0..full_vchanel3  input  1 each  full flag of vchanel FIFO N
push_vchanel0..push_vchanel3  output  1 each  registered push strobe into FIFO N
data_vchanel0..data_vchanel3  output  DATA_W each  registered write data for FIFO N
idle  output  1  registered; 1 when skid is empty and no read is in flight

Behaviour:
- Reset: rst==0 at a clk edge clears all state. The following are all 0: push_vchanel0..3, data_vchanel0..3, skid count, pop_d, idle-pending. idle becomes 1. in_pop is forced to 0 while rst==0.
- Reset mid-operation discards the word in flight (pop_d) and all skid contents. No push occurs on the cycle after reset.
- pop_d is a register equal to in_pop delayed by one cycle. When pop_d==1, {in_dest, in_data} is the "arrival" word this cycle.
- in_pop = rst & enb & !in_empty & ((cnt + pop_d) < 2), where cnt is the skid occupancy 0..2. This is conservative: any word popped always has a slot.
- Candidate selection each cycle: the skid head if cnt>0, else the arrival if pop_d==1, else none. Strict FIFO order; head-of-line blocking across channels is accepted.
- Dispatch: the candidate dispatches when enb==1 and full_vchanel[dest]==0. On the next edge:
  - push_vchanel[dest]<=1 and data_vchanel[dest]<=data.
  - All other push strobes go to 0.
  - data_vchanelN of non-pushed channels hold their value.
- Exactly one push at most per cycle; throughput is one word per cycle when unblocked.
- Skid update:
  - An arrival that is not dispatched this cycle is appended at the tail, including when the head was dispatched instead.
  - A dispatched head is removed.
  - The net cnt change lies in {-1, 0, +1}; cnt never exceeds 2 (bench asserts this).
- enb==0: in_pop=0 and no dispatch (all push 0), but an arrival from an earlier pop is still captured into the skid.
- A full flag that rises in the same cycle as a candidate blocks that candidate. The full flag is sampled combinationally.
- idle is registered next cycle as (cnt_next==0 && in_pop==0 && pop_d_next==0).

Optional Feature:
- Macro VCHANEL_DEMUX_STATS_EN.
- When defined, add output port stall_count [7:0]. It resets to 0 and increments (saturating at 255) every cycle in which a candidate exists, enb==1, and full_vchanel[dest]==1.
- When undefined, the port and the counter are absent. All other behaviour is identical.

Test Plan:
- Reset: hold rst=0 for 3 cycles with in_empty=0, enb=1 -> in_pop=0, all push_vchanelN=0, all data_vchanelN=0, idle=1. After rst=1, in_pop=1 in the first cycle.
- Streaming: upstream words (dest,data) = (0,4'hA),(1,4'hB),(2,4'hC),(3,4'hD), no full flags -> pushes on consecutive cycles to channels 0,1,2,3 with data A,B,C,D. Each push lands 2 cycles after its pop.
- Backpressure: full_vchanel2=1 for 6 cycles while a stream of dest=2 words arrives -> push_vchanel2 stays 0, cnt saturates at 2, in_pop drops. After full clears, all words are pushed in order with none lost or duplicated.
- Head-of-line: words (2,4'h1),(0,4'h2) with full_vchanel2=1 -> the channel 0 word is not pushed until the channel 2 word is pushed. Order 1 then 2.
- Enable/reset mid-flight: enb goes low on the cycle after in_pop -> the arrival is captured and pushed only after enb returns to 1. Separately, rst=0 with cnt=2 -> the skid is emptied and no pushes follow.
- Stats (VCHANEL_DEMUX_STATS_EN): full_vchanel1=1 for 10 cycles with a dest=1 candidate pending -> stall_count=10. Forcing 300 stall cycles -> stall_count=255.
